// File: rtl/tile_spawner.sv
// tile_spawner: drops a new tile into a pseudo-random empty cell of the 2048 board (TILE_SPAWNER_FOUR_EN enables 4-tiles)
module tile_spawner #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] matrix_in  [3:0][3:0],
  output logic [11:0] matrix_out [3:0][3:0],
  output logic        busy,
  output logic        done,
  output logic        full
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  state_t state, state_nx;
  logic [15:0] lfsr;
  logic [11:0] board [3:0][3:0];
  logic [3:0] p, c;
  logic empty;
  logic [11:0] tile;
  assign empty = board[p[3:2]][p[1:0]] == 12'd0;
  assign matrix_out = board;
  assign busy = state != IDLE;
  assign done = state == DONE;
`ifdef TILE_SPAWNER_FOUR_EN
  logic ts;
  assign tile = ts ? 12'd4 : 12'd2;
  // tile select is sampled from the LFSR together with the start pointer
  always_ff @(posedge clk)
    if (rst) ts <= 1'b0;
    else if (state == IDLE && start) ts <= lfsr[7:4] == 4'h0;
`else
  assign tile = 12'd2;
`endif
  // free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1
  always_ff @(posedge clk)
    if (rst) lfsr <= SEED;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: scan until an empty cell or the 16th occupied probe
  always_comb
    state_nx = state == IDLE ? (start ? SCAN : IDLE) :
               state == SCAN ? ((empty || &c) ? DONE : SCAN) : IDLE;
  // board latch, probe pointer/count and the single tile write
  always_ff @(posedge clk)
    if (rst) begin
      board <= '{default: 12'd0};
      p <= 4'd0;
      c <= 4'd0;
      full <= 1'b0;
    end else if (state == IDLE && start) begin
      board <= matrix_in;
      p <= lfsr[3:0];
      c <= 4'd0;
      full <= 1'b0;
    end else if (state == SCAN) begin
      if (empty) board[p[3:2]][p[1:0]] <= tile;
      else begin
        p <= p + 4'd1;
        c <= c + 4'd1;
        full <= &c;
      end
    end
endmodule
